// File: rtl/lab8_soc_avmm_pkg.sv
// Shared definitions for the Avalon-MM sequential master and the on-chip memory wrapper:
// FSM state encoding and default bus geometry.
package lab8_soc_avmm_pkg;

   localparam int DEFAULT_ADDR_W = 2;
   localparam int DEFAULT_DATA_W = 32;

   localparam logic [2:0] ST_IDLE     = 3'd0;
   localparam logic [2:0] ST_WR_DATA  = 3'd1;
   localparam logic [2:0] ST_WR_ISSUE = 3'd2;
   localparam logic [2:0] ST_RD_ISSUE = 3'd3;
   localparam logic [2:0] ST_RD_LAT   = 3'd4;
   localparam logic [2:0] ST_RD_HOLD  = 3'd5;

endpackage

// File: rtl/lab8_soc_avmm_seq_master.sv
// Avalon-MM master running sequential single-word read/write bursts against a fixed-latency
// on-chip RAM, with stream-side write-data input and read-data output.
module lab8_soc_avmm_seq_master
   import lab8_soc_avmm_pkg::*;
#(
   parameter int ADDR_W       = DEFAULT_ADDR_W,
   parameter int DATA_W       = DEFAULT_DATA_W,
   parameter int BE_W         = DATA_W / 8,
   parameter int READ_LATENCY = 1,
   parameter int LEN_W        = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_write,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [LEN_W-1:0]  cmd_len,
   input  logic [BE_W-1:0]   cmd_be,
   input  logic              wr_valid,
   output logic              wr_ready,
   input  logic [DATA_W-1:0] wr_data,
   output logic              rd_valid,
   input  logic              rd_ready,
   output logic [DATA_W-1:0] rd_data,
   output logic              busy,
   output logic [ADDR_W-1:0] avm_address,
   output logic [BE_W-1:0]   avm_byteenable,
   output logic [DATA_W-1:0] avm_writedata,
   output logic              avm_chipselect,
   output logic              avm_write,
   output logic              avm_read,
   input  logic [DATA_W-1:0] avm_readdata,
   input  logic              avm_waitrequest
);

   localparam int LAT_W = $clog2(READ_LATENCY + 1);

   logic [2:0]        state_r, state_nxt_s;
   logic [ADDR_W-1:0] addr_r, addr_nxt_s;
   logic [LEN_W-1:0]  rem_r, rem_nxt_s;
   logic [BE_W-1:0]   be_r, be_nxt_s;
   logic [DATA_W-1:0] wdata_r, wdata_nxt_s;
   logic [DATA_W-1:0] rdata_r, rdata_nxt_s;
   logic [LAT_W-1:0]  lat_r, lat_nxt_s;

   logic              cmd_ready_r, busy_r, wr_ready_r, rd_valid_r;
   logic              cs_r, write_r, read_r;
   logic [BE_W-1:0]   avm_be_r;

   // Next-state and datapath update for the burst sequencer.
   always_comb begin
      state_nxt_s = state_r;
      addr_nxt_s  = addr_r;
      rem_nxt_s   = rem_r;
      be_nxt_s    = be_r;
      wdata_nxt_s = wdata_r;
      rdata_nxt_s = rdata_r;
      lat_nxt_s   = lat_r;
      case (state_r)
         ST_IDLE: begin
            if (cmd_valid) begin
               state_nxt_s = cmd_write ? ST_WR_DATA : ST_RD_ISSUE;
               addr_nxt_s  = cmd_addr;
               rem_nxt_s   = cmd_len;
               be_nxt_s    = cmd_be;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_WR_DATA: begin
            if (wr_valid) begin
               wdata_nxt_s = wr_data;
               state_nxt_s = ST_WR_ISSUE;
            end else begin
               state_nxt_s = ST_WR_DATA;
            end
         end
         ST_WR_ISSUE: begin
            if (avm_waitrequest) begin
               state_nxt_s = ST_WR_ISSUE;
            end else if (rem_r == {LEN_W{1'b0}}) begin
               state_nxt_s = ST_IDLE;
            end else begin
               state_nxt_s = ST_WR_DATA;
               addr_nxt_s  = addr_r + ADDR_W'(1'b1);
               rem_nxt_s   = rem_r - LEN_W'(1'b1);
            end
         end
         ST_RD_ISSUE: begin
            // The acceptance edge itself counts as latency edge 0; the counter starts at 1.
            if (avm_waitrequest) begin
               state_nxt_s = ST_RD_ISSUE;
            end else begin
               state_nxt_s = ST_RD_LAT;
               lat_nxt_s   = LAT_W'(1'b1);
            end
         end
         ST_RD_LAT: begin
            if (lat_r == LAT_W'(READ_LATENCY)) begin
               rdata_nxt_s = avm_readdata;
               state_nxt_s = ST_RD_HOLD;
            end else begin
               lat_nxt_s   = lat_r + LAT_W'(1'b1);
            end
         end
         ST_RD_HOLD: begin
            if (!rd_ready) begin
               state_nxt_s = ST_RD_HOLD;
            end else if (rem_r == {LEN_W{1'b0}}) begin
               state_nxt_s = ST_IDLE;
            end else begin
               state_nxt_s = ST_RD_ISSUE;
               addr_nxt_s  = addr_r + ADDR_W'(1'b1);
               rem_nxt_s   = rem_r - LEN_W'(1'b1);
            end
         end
         default: begin
            state_nxt_s = ST_IDLE;
         end
      endcase
   end

   // State and datapath registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r <= ST_IDLE;
         addr_r  <= {ADDR_W{1'b0}};
         rem_r   <= {LEN_W{1'b0}};
         be_r    <= {BE_W{1'b0}};
         wdata_r <= {DATA_W{1'b0}};
         rdata_r <= {DATA_W{1'b0}};
         lat_r   <= {LAT_W{1'b0}};
      end else begin
         state_r <= state_nxt_s;
         addr_r  <= addr_nxt_s;
         rem_r   <= rem_nxt_s;
         be_r    <= be_nxt_s;
         wdata_r <= wdata_nxt_s;
         rdata_r <= rdata_nxt_s;
         lat_r   <= lat_nxt_s;
      end
   end

   // Control outputs are registered from the next state so they are pure flop outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         cmd_ready_r <= 1'b1;
         busy_r      <= 1'b0;
         wr_ready_r  <= 1'b0;
         rd_valid_r  <= 1'b0;
         cs_r        <= 1'b0;
         write_r     <= 1'b0;
         read_r      <= 1'b0;
         avm_be_r    <= {BE_W{1'b0}};
      end else begin
         cmd_ready_r <= (state_nxt_s == ST_IDLE);
         busy_r      <= (state_nxt_s != ST_IDLE);
         wr_ready_r  <= (state_nxt_s == ST_WR_DATA);
         rd_valid_r  <= (state_nxt_s == ST_RD_HOLD);
         cs_r        <= (state_nxt_s == ST_WR_ISSUE) || (state_nxt_s == ST_RD_ISSUE);
         write_r     <= (state_nxt_s == ST_WR_ISSUE);
         read_r      <= (state_nxt_s == ST_RD_ISSUE);
         if (state_nxt_s == ST_WR_ISSUE) begin
            avm_be_r <= be_nxt_s;
         end else if (state_nxt_s == ST_RD_ISSUE) begin
            avm_be_r <= {BE_W{1'b1}};
         end else begin
            avm_be_r <= {BE_W{1'b0}};
         end
      end
   end

   assign cmd_ready      = cmd_ready_r;
   assign busy           = busy_r;
   assign wr_ready       = wr_ready_r;
   assign rd_valid       = rd_valid_r;
   assign rd_data        = rdata_r;
   assign avm_address    = addr_r;
   assign avm_byteenable = avm_be_r;
   assign avm_writedata  = wdata_r;
   assign avm_chipselect = cs_r;
   assign avm_write      = write_r;
   assign avm_read       = read_r;

endmodule

// File: tb/tb_lab8_soc_avmm_seq_master.sv
// Bench: DUT plus a 4x32 latency-1 single-port RAM; a word-array model tracks expected contents.
module tb_lab8_soc_avmm_seq_master;

   logic        clk = 1'b0;
   logic        reset;
   logic        cmd_valid, cmd_ready, cmd_write;
   logic [1:0]  cmd_addr;
   logic [7:0]  cmd_len;
   logic [3:0]  cmd_be;
   logic        wr_valid, wr_ready;
   logic [31:0] wr_data;
   logic        rd_valid, rd_ready;
   logic [31:0] rd_data;
   logic        busy;
   logic [1:0]  avm_address;
   logic [3:0]  avm_byteenable;
   logic [31:0] avm_writedata;
   logic        avm_chipselect, avm_write, avm_read;
   logic [31:0] avm_readdata;
   logic        avm_waitrequest;

   logic [31:0] ram     [0:3] = '{32'h0, 32'h0, 32'h0, 32'h0};
   logic [31:0] exp_mem [0:3] = '{32'h0, 32'h0, 32'h0, 32'h0};
   logic [31:0] wbuf    [0:255];
   int          wcnt = 0;
   int          rcnt = 0;
   int          checks = 0;
   int          failures = 0;

   always #5 clk = ~clk;

   lab8_soc_avmm_seq_master dut (
      .clk(clk), .reset(reset),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_be(cmd_be),
      .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
      .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
      .busy(busy),
      .avm_address(avm_address), .avm_byteenable(avm_byteenable),
      .avm_writedata(avm_writedata), .avm_chipselect(avm_chipselect),
      .avm_write(avm_write), .avm_read(avm_read),
      .avm_readdata(avm_readdata), .avm_waitrequest(avm_waitrequest)
   );

   function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                         input logic [3:0] be);
      logic [31:0] r;
      r = old_w;
      for (int b = 0; b < 4; b++) begin
         if (be[b]) r[8*b +: 8] = new_w[8*b +: 8];
      end
      return r;
   endfunction

   // RAM returns garbage except on the cycle after an accepted read.
   always @(posedge clk) begin
      if (avm_chipselect && !avm_waitrequest && avm_write) begin
         ram[avm_address] <= merge(ram[avm_address], avm_writedata, avm_byteenable);
         wcnt <= wcnt + 1;
      end
      if (avm_chipselect && !avm_waitrequest && avm_read) begin
         avm_readdata <= ram[avm_address];
         rcnt <= rcnt + 1;
      end else begin
         avm_readdata <= $urandom;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      chk("rw_exclusive", {31'd0, avm_write & avm_read}, 32'd0);
      chk("cs_decode", {31'd0, avm_chipselect}, {31'd0, avm_write | avm_read});
      if (avm_read) chk("rd_be_ones", {28'd0, avm_byteenable}, 32'h0000000F);
   endtask

   task automatic compare_ram(input string tag);
      for (int k = 0; k < 4; k++) chk(tag, ram[k], exp_mem[k]);
   endtask

   task automatic issue_cmd(input logic wr, input logic [1:0] a, input logic [7:0] len,
                            input logic [3:0] be);
      int n = 0;
      while (!cmd_ready && n < 100) begin tick(); n++; end
      chk("cmd_ready_wait", {31'd0, cmd_ready}, 32'd1);
      cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_len = len; cmd_be = be;
      tick();
      cmd_valid = 1'b0;
      cmd_write = ~wr; cmd_addr = 2'($urandom); cmd_len = 8'($urandom); cmd_be = 4'($urandom);
   endtask

   task automatic push_word(input logic [31:0] d, input int gap);
      int n = 0;
      repeat (gap) tick();
      wr_valid = 1'b1; wr_data = d;
      while (!wr_ready && n < 50) begin tick(); n++; end
      chk("wr_ready_wait", {31'd0, wr_ready}, 32'd1);
      tick();
      wr_valid = 1'b0; wr_data = $urandom;
   endtask

   task automatic pull_word(input logic [31:0] exp, input int hold);
      int n = 0;
      int r0;
      while (!rd_valid && n < 50) begin tick(); n++; end
      chk("rd_valid_wait", {31'd0, rd_valid}, 32'd1);
      r0 = rcnt;
      repeat (hold) begin
         chk("rd_data_held", rd_data, exp);
         chk("rd_valid_held", {31'd0, rd_valid}, 32'd1);
         chk("no_read_while_held", 32'(rcnt - r0), 32'd0);
         tick();
      end
      chk("rd_data", rd_data, exp);
      rd_ready = 1'b1;
      tick();
      rd_ready = 1'b0;
   endtask

   task automatic wait_idle();
      int n = 0;
      while (!cmd_ready && n < 100) begin tick(); n++; end
      chk("idle_cmd_ready", {31'd0, cmd_ready}, 32'd1);
      chk("idle_busy", {31'd0, busy}, 32'd0);
   endtask

   task automatic run_cmd(input logic wr, input logic [1:0] a, input logic [7:0] len,
                          input logic [3:0] be, input int hold_max);
      int w0, r0;
      logic [1:0] ad;
      w0 = wcnt; r0 = rcnt;
      issue_cmd(wr, a, len, be);
      for (int i = 0; i <= int'(len); i++) begin
         ad = a + i[1:0];
         if (wr) begin
            push_word(wbuf[i], int'($urandom_range(0, hold_max)));
            exp_mem[ad] = merge(exp_mem[ad], wbuf[i], be);
         end else begin
            pull_word(exp_mem[ad], int'($urandom_range(0, hold_max)));
         end
      end
      wait_idle();
      chk("avm_write_count", 32'(wcnt - w0), wr ? 32'(int'(len) + 1) : 32'd0);
      chk("avm_read_count", 32'(rcnt - r0), wr ? 32'd0 : 32'(int'(len) + 1));
      compare_ram("ram_vs_model");
   endtask

   initial begin
      int w0;
      reset = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 2'd0; cmd_len = 8'd0;
      cmd_be = 4'd0; wr_valid = 1'b0; wr_data = 32'd0; rd_ready = 1'b0; avm_waitrequest = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_wr_ready", {31'd0, wr_ready}, 32'd0);
      chk("rst_rd_valid", {31'd0, rd_valid}, 32'd0);
      chk("rst_rd_data", rd_data, 32'd0);
      chk("rst_avm_ctl", {29'd0, avm_chipselect, avm_write, avm_read}, 32'd0);
      chk("rst_avm_addr_be", {26'd0, avm_address, avm_byteenable}, 32'd0);
      chk("rst_avm_wdata", avm_writedata, 32'd0);
      reset = 1'b0;
      tick();

      // 4-word write then read back in order
      wbuf[0] = 32'h11; wbuf[1] = 32'h22; wbuf[2] = 32'h33; wbuf[3] = 32'h44;
      run_cmd(1'b1, 2'd0, 8'd3, 4'hF, 0);
      run_cmd(1'b0, 2'd0, 8'd3, 4'hF, 0);

      // address wrap 3 -> 0
      wbuf[0] = 32'hA5A5A5A5; wbuf[1] = 32'h5A5A5A5A;
      run_cmd(1'b1, 2'd3, 8'd1, 4'hF, 1);
      chk("wrap_ram3", ram[3], 32'hA5A5A5A5);
      chk("wrap_ram0", ram[0], 32'h5A5A5A5A);

      // partial byteenable
      wbuf[0] = 32'hFFFFFFFF;
      run_cmd(1'b1, 2'd1, 8'd0, 4'hF, 0);
      wbuf[0] = 32'h12345678;
      run_cmd(1'b1, 2'd1, 8'd0, 4'b0011, 0);
      chk("partial_ram1", ram[1], 32'hFFFF5678);
      run_cmd(1'b0, 2'd1, 8'd0, 4'hF, 0);

      // waitrequest stall on a write: outputs frozen for 3 cycles, one update
      avm_waitrequest = 1'b1;
      w0 = wcnt;
      issue_cmd(1'b1, 2'd2, 8'd0, 4'hF);
      push_word(32'hDEADBEEF, 0);
      for (int c = 0; c < 3; c++) begin
         if (c == 2) avm_waitrequest = 1'b0;
         chk("stall_ctl", {29'd0, avm_chipselect, avm_write, avm_read}, 32'd6);
         chk("stall_addr", {30'd0, avm_address}, 32'd2);
         chk("stall_be", {28'd0, avm_byteenable}, 32'hF);
         chk("stall_wdata", avm_writedata, 32'hDEADBEEF);
         chk("stall_no_write_yet", 32'(wcnt - w0), 32'd0);
         tick();
      end
      exp_mem[2] = 32'hDEADBEEF;
      chk("stall_cs_drop", {31'd0, avm_chipselect}, 32'd0);
      chk("stall_one_write", 32'(wcnt - w0), 32'd1);
      wait_idle();
      compare_ram("stall_ram");

      // rd_ready held low 5 cycles on a 2-word read
      issue_cmd(1'b0, 2'd1, 8'd1, 4'h0);
      pull_word(exp_mem[1], 5);
      pull_word(exp_mem[2], 0);
      wait_idle();

      // reset while waiting for the 3rd write word of a 4-word burst
      w0 = wcnt;
      issue_cmd(1'b1, 2'd0, 8'd3, 4'hF);
      push_word(32'hC0DE0000, 0); exp_mem[0] = 32'hC0DE0000;
      push_word(32'hC0DE0001, 0); exp_mem[1] = 32'hC0DE0001;
      for (int n = 0; n < 20 && !wr_ready; n++) tick();
      chk("pre_reset_wr_ready", {31'd0, wr_ready}, 32'd1);
      reset = 1'b1;
      wr_valid = 1'b1; wr_data = 32'hBAD0BAD0;
      tick();
      reset = 1'b0;
      chk("reset_cmd_ready", {31'd0, cmd_ready}, 32'd1);
      chk("reset_cs", {31'd0, avm_chipselect}, 32'd0);
      chk("reset_wr_ready", {31'd0, wr_ready}, 32'd0);
      wr_valid = 1'b0;
      repeat (6) tick();
      chk("reset_write_count", 32'(wcnt - w0), 32'd2);
      compare_ram("reset_ram");

      // randomized bursts against the word-array model
      for (int t = 0; t < 30; t++) begin
         for (int i = 0; i < 8; i++) wbuf[i] = $urandom;
         run_cmd(1'($urandom_range(0, 1)), 2'($urandom), 8'($urandom_range(0, 6)),
                 4'($urandom), 3);
      end
      run_cmd(1'b0, 2'd0, 8'd3, 4'hF, 2);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
